// File: rtl/serial_fs_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_fs_sub_pkg
//
// Purpose:
//   Shared types and elaboration-time helpers for the digit-serial subtractor.
//   Holds the controller state encoding and the functions that derive the
//   number of RUN steps and the step-counter width from WIDTH and DIGIT.
//
// Contents:
//   state_e             controller state, 2-bit encoding {IDLE, RUN, DONE}
//   calcNstep()         WIDTH / DIGIT, the number of slices per operation
//   calcCountWidth()    clog2(NSTEP), never smaller than one bit
// ---------------------------------------------------------------------------
package serial_fs_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT-bit slices that make up one WIDTH-bit operand.
  function automatic int calcNstep(input int width, input int digit);
    return width / digit;
  endfunction

  // The step counter only has to reach NSTEP-1; a single-step build still
  // keeps a one-bit counter so the datapath never sees a zero-width vector.
  function automatic int calcCountWidth(input int width, input int digit);
    int nStep;
    nStep = calcNstep(width, digit);
    if (nStep <= 1) begin
      return 1;
    end
    return $clog2(nStep);
  endfunction

endpackage

// File: rtl/serial_fs_sub_fs_digit.sv
// ---------------------------------------------------------------------------
// fs_digit
//
// Purpose:
//   Purely combinational DIGIT-bit ripple subtractor built from full-subtractor
//   cells. Computes {bout, d_slice} = a_slice - b_slice - bin.
//
// Ports:
//   a_slice  in   DIGIT  minuend slice
//   b_slice  in   DIGIT  subtrahend slice
//   bin      in   1      borrow into the least significant cell
//   d_slice  out  DIGIT  difference slice
//   bout     out  1      borrow out of the most significant cell
// ---------------------------------------------------------------------------
module fs_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_slice,
  input  logic [DIGIT-1:0] b_slice,
  input  logic             bin,
  output logic [DIGIT-1:0] d_slice,
  output logic             bout
);

  // borrowChain[i] is the borrow entering cell i; the extra top entry is the
  // borrow leaving the slice.
  logic [DIGIT:0] borrowChain;

  assign borrowChain[0] = bin;

  // A full-subtractor cell borrows when the minuend bit is 0 and the
  // subtrahend bit is 1, or when the two bits are equal and a borrow arrives.
  for (genvar i = 0; i < DIGIT; i++) begin : gCell
    assign d_slice[i]       = a_slice[i] ^ b_slice[i] ^ borrowChain[i];
    assign borrowChain[i+1] = (~a_slice[i] & b_slice[i])
                            | (~(a_slice[i] ^ b_slice[i]) & borrowChain[i]);
  end

  assign bout = borrowChain[DIGIT];

endmodule

// File: rtl/serial_fs_sub.sv
// ---------------------------------------------------------------------------
// serial_fs_sub
//
// Purpose:
//   Multi-cycle subtractor computing diff = a - b - bin over WIDTH bits,
//   DIGIT bits per clock, least significant slice first. The borrow between
//   slices is carried in a register, so one small fs_digit slice is reused
//   NSTEP = WIDTH/DIGIT times per operation. Operands are accepted and the
//   result is delivered over valid/ready handshakes.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of DIGIT
//   DIGIT  bits processed per RUN cycle, 1 <= DIGIT <= WIDTH
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands present
//   in_ready   out  1      block can accept operands (IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result present (DONE)
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  difference, modulo 2^WIDTH
//   bout       out  1      borrow-out of the most significant slice
//   busy       out  1      high in RUN or DONE
//
// Build option:
//   SERIAL_FS_SUB_SAT_EN  when defined, a result that borrows out is clamped
//                         to zero (bout still reads 1); handshake timing is
//                         unchanged.
// ---------------------------------------------------------------------------
module serial_fs_sub
  import serial_fs_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int NSTEP = calcNstep(WIDTH, DIGIT);
  localparam int CW    = calcCountWidth(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [DIGIT-1:0] aSlice;
  logic [DIGIT-1:0] bSlice;
  logic [DIGIT-1:0] dSlice;
  logic             brwNext;
  logic [WIDTH-1:0] shiftNext;
  logic [WIDTH-1:0] diffFinal;
  logic             lastStep;

  // The slice under work is selected by the step counter, so the operand
  // registers stay untouched for the whole operation.
  assign aSlice   = aReg_q[int'(count_q)*DIGIT +: DIGIT];
  assign bSlice   = bReg_q[int'(count_q)*DIGIT +: DIGIT];
  assign lastStep = (count_q == LAST_STEP);

  fs_digit #(
    .DIGIT(DIGIT)
  ) uDigit (
    .a_slice(aSlice),
    .b_slice(bSlice),
    .bin    (borrow_q),
    .d_slice(dSlice),
    .bout   (brwNext)
  );

  // New slices enter from the MSB side so that, after NSTEP shifts, slice 0
  // ends up at the LSB. A single-step build has nothing to shift.
  if (NSTEP == 1) begin : gOneStep
    assign shiftNext = dSlice;
  end else begin : gMultiStep
    assign shiftNext = {dSlice, shiftReg_q[WIDTH-1:DIGIT]};
  end

  // The completed difference, optionally clamped when the whole operation
  // borrows out of the top slice.
`ifdef SERIAL_FS_SUB_SAT_EN
  assign diffFinal = brwNext ? '0 : shiftNext;
`else
  assign diffFinal = shiftNext;
`endif

  // State register: asynchronous reset forces IDLE immediately, which also
  // drops out_valid and busy without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, step through NSTEP slices in RUN, and
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (lastStep) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  // Datapath next-state: operands and the incoming borrow are captured on
  // acceptance; each RUN cycle advances the borrow and shift registers. The
  // visible result registers only change on the final step, so a partial
  // result is never exposed and the previous result is held until then.
  always_comb begin
    aReg_d     = aReg_q;
    bReg_d     = bReg_q;
    borrow_d   = borrow_q;
    count_d    = count_q;
    shiftReg_d = shiftReg_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aReg_d   = a;
          bReg_d   = b;
          borrow_d = bin;
          count_d  = '0;
        end
      end
      RUN: begin
        borrow_d   = brwNext;
        shiftReg_d = shiftNext;
        if (lastStep) begin
          diff_d  = diffFinal;
          bout_d  = brwNext;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg_q     <= '0;
      bReg_q     <= '0;
      borrow_q   <= 1'b0;
      count_q    <= '0;
      shiftReg_q <= '0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
    end else begin
      aReg_q     <= aReg_d;
      bReg_q     <= bReg_d;
      borrow_q   <= borrow_d;
      count_q    <= count_d;
      shiftReg_q <= shiftReg_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_fs_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_fs_sub
//
// Purpose:
//   Self-checking bench for serial_fs_sub. Two instances share the operand
//   and reset inputs: a WIDTH=8/DIGIT=2 build (four steps) and a
//   WIDTH=8/DIGIT=8 build (single step). Directed cases and random vectors
//   are compared against a plain-arithmetic reference of a - b - bin.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_fs_sub;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_ready;

  logic       inValid2, inReady2, outValid2, bout2, busy2;
  logic [7:0] diff2;
  logic       inValid8, inReady8, outValid8, bout8, busy8;
  logic [7:0] diff8;

  // sel picks the instance under test: 0 = four-step, 1 = single-step.
  logic       sel;
  logic       mInReady, mOutValid, mBout, mBusy;
  logic [7:0] mDiff;

  int checks;
  int failures;

  serial_fs_sub #(.WIDTH(8), .DIGIT(2)) dutStep4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady2),
    .a(a), .b(b), .bin(bin), .out_valid(outValid2), .out_ready(out_ready),
    .diff(diff2), .bout(bout2), .busy(busy2)
  );

  serial_fs_sub #(.WIDTH(8), .DIGIT(8)) dutStep1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
    .a(a), .b(b), .bin(bin), .out_valid(outValid8), .out_ready(out_ready),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // View of whichever instance is currently under test.
  always_comb begin
    mInReady  = sel ? inReady8  : inReady2;
    mOutValid = sel ? outValid8 : outValid2;
    mDiff     = sel ? diff8     : diff2;
    mBout     = sel ? bout8     : bout2;
    mBusy     = sel ? busy8     : busy2;
  end

  // Reference: a - b - bin as unbounded integers; the borrow is simply
  // whether that value went negative.
  function automatic logic [8:0] refSub(input logic [7:0] av,
                                        input logic [7:0] bv,
                                        input logic binv);
    int full;
    logic [7:0] d;
    logic bo;
    full = int'(av) - int'(bv) - int'(binv);
    bo   = (full < 0);
    d    = 8'(full);
`ifdef SERIAL_FS_SUB_SAT_EN
    if (bo) d = 8'h00;
`endif
    return {bo, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setInValid(input logic v);
    if (sel) inValid8 = v;
    else     inValid2 = v;
  endtask

  // One full operation on the selected instance. hold = 0 keeps out_ready
  // high throughout; otherwise out_ready stays low for hold cycles of DONE
  // while in_valid is pulsed, to show nothing new is accepted.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic binv, input int hold);
    logic [8:0] expv;
    int         nStep;
    int         lat;
    bit         seen;
    nStep = sel ? 1 : 4;
    expv  = refSub(av, bv, binv);

    @(negedge clk);
    a         = av;
    b         = bv;
    bin       = binv;
    out_ready = (hold == 0);
    setInValid(1'b1);
    checkOutput("inReadyBeforeAccept", 32'(mInReady), 32'd1);

    @(posedge clk);
    #1;
    setInValid(1'b0);
    // Operands only need to be stable at the accept edge.
    a   = 8'($urandom);
    b   = 8'($urandom);
    bin = 1'($urandom);

    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      checkOutput("inReadyLowBusy", 32'(mInReady), 32'd0);
      checkOutput("busyHigh", 32'(mBusy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
      if (mOutValid) seen = 1;
    end
    if (!seen) begin
      checkOutput("outValidTimeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(lat), 32'(nStep));
    checkOutput("diff", 32'(mDiff), 32'(expv[7:0]));
    checkOutput("bout", 32'(mBout), 32'(expv[8]));
    checkOutput("inReadyLowDone", 32'(mInReady), 32'd0);

    if (hold > 0) begin
      setInValid(1'b1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checkOutput("holdValid", 32'(mOutValid), 32'd1);
        checkOutput("holdDiff", 32'(mDiff), 32'(expv[7:0]));
        checkOutput("holdBout", 32'(mBout), 32'(expv[8]));
        checkOutput("holdInReady", 32'(mInReady), 32'd0);
      end
      setInValid(1'b0);
      out_ready = 1'b1;
    end

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("validDrop", 32'(mOutValid), 32'd0);
    checkOutput("inReadyIdle", 32'(mInReady), 32'd1);
    checkOutput("busyIdle", 32'(mBusy), 32'd0);
    checkOutput("diffKept", 32'(mDiff), 32'(expv[7:0]));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "InReady"},  32'(mInReady),  32'd1);
    checkOutput({tag, "OutValid"}, 32'(mOutValid), 32'd0);
    checkOutput({tag, "Busy"},     32'(mBusy),     32'd0);
    checkOutput({tag, "Diff"},     32'(mDiff),     32'd0);
    checkOutput({tag, "Bout"},     32'(mBout),     32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    inValid2  = 1'b0;
    inValid8  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    checkResetValues("rst4");
    sel = 1'b1;
    checkResetValues("rst1");
    @(negedge clk);
    rst_n = 1'b1;

    // Four-step instance: directed cases.
    sel = 1'b0;
    applyStimulus(8'h5A, 8'h3C, 1'b0, 0);
    applyStimulus(8'h00, 8'h01, 1'b0, 1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    applyStimulus(8'h10, 8'h0F, 1'b1, 0);
    applyStimulus(8'h80, 8'h01, 1'b0, 5);

    // Asynchronous reset one step into RUN.
    @(negedge clk);
    a = 8'h44; b = 8'h22; bin = 1'b0;
    inValid2 = 1'b1;
    @(posedge clk);
    #1;
    inValid2 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midRun");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h33, 8'h11, 1'b0, 0);

    // Single-step instance.
    sel = 1'b1;
    applyStimulus(8'h05, 8'h07, 1'b0, 0);
    applyStimulus(8'hFF, 8'h00, 1'b1, 2);

    // Random vectors on both instances.
    sel = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
    end
    sel = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
